// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: optional dirty-victim write-back, then an ascending 4-word line refill.
// Define DCACHE_WRITEBACK_EN to include the WB state and victim capture; otherwise every miss goes IDLE->FILL.
module dcache_refill_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         miss_req,
  input  logic [31:0]  miss_addr,
  input  logic         victim_dirty,
  input  logic [31:0]  victim_addr,
  input  logic [127:0] victim_line,
  output logic         busy,
  output logic         refill_valid,
  output logic [31:0]  refill_addr,
  output logic [127:0] refill_line,
  output logic [31:0]  D_MEM_ADDR,
  output logic [31:0]  D_MEM_DO,
  output logic         D_MEM_WEN,
  input  logic [31:0]  D_MEM_DI
);

  localparam int         LINE_WORDS = 4;
  localparam logic [1:0] WORD_LAST  = 2'(LINE_WORDS - 1);
  localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  state_t      state;
  logic [3:0]  lat;
  logic [1:0]  word;
  logic [1:0]  word_nxt;
  logic        lat_wrap;
  logic [27:0] miss_tag;
  logic        unused_bits;

  assign word_nxt = word + 2'd1;
  assign lat_wrap = (lat == LAT_LAST);

`ifdef DCACHE_WRITEBACK_EN
  logic [27:0]  victim_tag;
  logic [127:0] victim_q;
  assign unused_bits = ^{miss_addr[3:0], victim_addr[3:0]};
`else
  // Without write-back the memory port is read-only and the victim inputs are dead.
  assign unused_bits = ^{miss_addr[3:0], victim_dirty, victim_addr, victim_line};
  assign D_MEM_WEN   = 1'b1;
  assign D_MEM_DO    = 32'd0;
`endif

  // Every output is loaded together with the state/counter move that selects it, so all are registered.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      lat          <= 4'd0;
      word         <= 2'd0;
      miss_tag     <= 28'd0;
      busy         <= 1'b0;
      refill_valid <= 1'b0;
      refill_addr  <= 32'd0;
      refill_line  <= 128'd0;
      D_MEM_ADDR   <= 32'd0;
`ifdef DCACHE_WRITEBACK_EN
      victim_tag   <= 28'd0;
      victim_q     <= 128'd0;
      D_MEM_DO     <= 32'd0;
      D_MEM_WEN    <= 1'b1;
`endif
    end else begin
      refill_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            miss_tag <= miss_addr[31:4];
            lat      <= 4'd0;
            word     <= 2'd0;
            busy     <= 1'b1;
`ifdef DCACHE_WRITEBACK_EN
            victim_tag <= victim_addr[31:4];
            victim_q   <= victim_line;
            if (victim_dirty) begin
              state      <= WB;
              D_MEM_ADDR <= {victim_addr[31:4], 4'b0000};
              D_MEM_DO   <= victim_line[31:0];
              D_MEM_WEN  <= 1'b0;
            end else begin
              state      <= FILL;
              D_MEM_ADDR <= {miss_addr[31:4], 4'b0000};
            end
`else
            state      <= FILL;
            D_MEM_ADDR <= {miss_addr[31:4], 4'b0000};
`endif
          end
        end
`ifdef DCACHE_WRITEBACK_EN
        WB: begin
          if (lat_wrap) begin
            lat <= 4'd0;
            if (word == WORD_LAST) begin
              state      <= FILL;
              word       <= 2'd0;
              D_MEM_ADDR <= {miss_tag, 4'b0000};
              D_MEM_DO   <= 32'd0;
              D_MEM_WEN  <= 1'b1;
            end else begin
              word       <= word_nxt;
              D_MEM_ADDR <= {victim_tag, word_nxt, 2'b00};
              D_MEM_DO   <= victim_q[{word_nxt, 5'b00000} +: 32];
            end
          end else begin
            lat <= lat + 4'd1;
          end
        end
`endif
        FILL: begin
          if (lat_wrap) begin
            lat <= 4'd0;
            refill_line[{word, 5'b00000} +: 32] <= D_MEM_DI;
            if (word == WORD_LAST) begin
              state        <= DONE;
              word         <= 2'd0;
              busy         <= 1'b0;
              refill_valid <= 1'b1;
              refill_addr  <= {miss_tag, 4'b0000};
              D_MEM_ADDR   <= 32'd0;
            end else begin
              word       <= word_nxt;
              D_MEM_ADDR <= {miss_tag, word_nxt, 2'b00};
            end
          end else begin
            lat <= lat + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: directed vector table, random misses against a
// cycle-timeline model, and hand-written reset sequences. Honours DCACHE_WRITEBACK_EN like the DUT.
module tb_dcache_refill_ctrl;

  localparam int MEM_LAT = 2;

  logic         CLK = 1'b0;
  logic         RSTn;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         victim_dirty;
  logic [31:0]  victim_addr;
  logic [127:0] victim_line;
  logic         busy;
  logic         refill_valid;
  logic [31:0]  refill_addr;
  logic [127:0] refill_line;
  logic [31:0]  D_MEM_ADDR;
  logic [31:0]  D_MEM_DO;
  logic         D_MEM_WEN;
  logic [31:0]  D_MEM_DI;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0]  maddr;
    logic         dirty;
    logic [31:0]  vaddr;
    logic [127:0] vline;
    bit           churn;
    bit           hold;
    logic [31:0]  exp_raddr;
    logic [127:0] exp_line;
  } vec_t;

  vec_t tbl[6];

  dcache_refill_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_addr(victim_addr), .victim_line(victim_line),
    .busy(busy), .refill_valid(refill_valid), .refill_addr(refill_addr), .refill_line(refill_line),
    .D_MEM_ADDR(D_MEM_ADDR), .D_MEM_DO(D_MEM_DO), .D_MEM_WEN(D_MEM_WEN), .D_MEM_DI(D_MEM_DI)
  );

  always #5 CLK = ~CLK;

  // Data memory: a fixed image at line 0x1230, a scrambled pattern everywhere else.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] idx;
    idx = {30'd0, a[3:2]} + 32'd1;
    if (a[31:4] == 28'h0000123) return 32'h11 * idx;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word({a[31:4], 2'(w), 2'b00});
    return l;
  endfunction

  assign D_MEM_DI = mem_word(D_MEM_ADDR);

  function automatic logic wb_taken(input logic dirty);
`ifdef DCACHE_WRITEBACK_EN
    return dirty;
`else
    return 1'b0 & dirty;
`endif
  endfunction

  // Expected {busy, refill_valid, D_MEM_WEN, D_MEM_ADDR, D_MEM_DO} in cycle k after acceptance.
  function automatic logic [66:0] exp_trace(input vec_t v, input logic wb, input int k);
    int base;
    int w;
    base = wb ? 4 * MEM_LAT : 0;
    if (k <= base) begin
      w = (k - 1) / MEM_LAT;
      return {1'b1, 1'b0, 1'b0, v.vaddr[31:4], 2'(w), 2'b00, v.vline[w*32 +: 32]};
    end
    if (k <= base + 4 * MEM_LAT) begin
      w = (k - base - 1) / MEM_LAT;
      return {1'b1, 1'b0, 1'b1, v.maddr[31:4], 2'(w), 2'b00, 32'd0};
    end
    return {1'b0, 1'b1, 1'b1, 32'd0, 32'd0};
  endfunction

  localparam logic [66:0] IDLE_TRACE = {1'b0, 1'b0, 1'b1, 32'd0, 32'd0};

  function automatic logic [66:0] act_trace();
    return {busy, refill_valid, D_MEM_WEN, D_MEM_ADDR, D_MEM_DO};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Enter in an IDLE cycle away from the edge; leave in the IDLE cycle following DONE.
  task automatic apply_stimulus(input vec_t v);
    logic wb;
    int   t_done;
    wb     = wb_taken(v.dirty);
    t_done = (wb ? 8 : 4) * MEM_LAT + 1;
    miss_req     = 1'b1;
    miss_addr    = v.maddr;
    victim_dirty = v.dirty;
    victim_addr  = v.vaddr;
    victim_line  = v.vline;
    @(posedge CLK);
    #2;
    if (v.churn) begin
      miss_req     = 1'b0;
      miss_addr    = 32'hFFFF_FFF0;
      victim_dirty = ~v.dirty;
      victim_addr  = $urandom;
      victim_line  = {$urandom, $urandom, $urandom, $urandom};
    end
    for (int k = 1; k <= t_done; k++) begin
      if (k > 1) begin
        @(posedge CLK);
        #2;
      end
      check_output($sformatf("trace %h k=%0d", v.maddr, k), 128'(act_trace()), 128'(exp_trace(v, wb, k)));
    end
    check_output("refill_addr", 128'(refill_addr), 128'(v.exp_raddr));
    check_output("refill_line", refill_line, v.exp_line);
    if (!v.hold) miss_req = 1'b0;
    @(posedge CLK);
    #2;
    check_output("idle after done", 128'(act_trace()), 128'(IDLE_TRACE));
  endtask

  initial begin
    vec_t v;
    int   seen;

    tbl[0] = '{32'h0000_1234, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, 32'h0000_1230,
               {32'h44, 32'h33, 32'h22, 32'h11}};
    tbl[1] = '{32'h0000_3008, 1'b1, 32'h0000_2000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b0, 1'b0,
               32'h0000_3000, mem_line(32'h0000_3000)};
    tbl[2] = '{32'h0000_5674, 1'b1, 32'h0000_4440, {4{32'hDEAD_BEEF}}, 1'b1, 1'b0,
               32'h0000_5670, mem_line(32'h0000_5670)};
    tbl[3] = '{32'h0000_7ABC, 1'b0, 32'h0, 128'h0, 1'b0, 1'b1, 32'h0000_7AB0, mem_line(32'h0000_7AB0)};
    tbl[4] = '{32'h0000_800C, 1'b1, 32'hABCD_EF00, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, 1'b0,
               32'h0000_8000, mem_line(32'h0000_8000)};
    tbl[5] = '{32'h0000_1238, 1'b0, 32'h0, 128'h0, 1'b0, 1'b0, 32'h0000_1230,
               {32'h44, 32'h33, 32'h22, 32'h11}};

    RSTn = 1'b1;
    miss_req = 1'b0;
    miss_addr = 32'd0;
    victim_dirty = 1'b0;
    victim_addr = 32'd0;
    victim_line = 128'd0;
    #1 RSTn = 1'b0;
    #2;
    check_output("reset outputs", 128'(act_trace()), 128'(IDLE_TRACE));
    check_output("reset refill", {refill_addr, refill_line[95:0]}, 128'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #2;
      check_output($sformatf("post-reset idle c=%0d", c), 128'(act_trace()), 128'(IDLE_TRACE));
    end

    for (int i = 0; i < 5; i++) apply_stimulus(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      v.maddr = $urandom;
      v.dirty = 1'($urandom_range(0, 1));
      v.vaddr = $urandom;
      v.vline = {$urandom, $urandom, $urandom, $urandom};
      v.churn = ($urandom_range(0, 3) == 0);
      v.hold  = (i < 19) && ($urandom_range(0, 2) == 0);
      v.exp_raddr = {v.maddr[31:4], 4'b0000};
      v.exp_line  = mem_line(v.maddr);
      apply_stimulus(v);
    end

    // Reset while FILL is on word 2: everything snaps back and no refill pulse follows.
    miss_req = 1'b0;
    @(posedge CLK);
    #2;
    v = tbl[0];
    v.maddr = 32'h0000_9990;
    miss_req = 1'b1;
    miss_addr = v.maddr;
    victim_dirty = 1'b0;
    @(posedge CLK);
    repeat (2 * MEM_LAT) @(posedge CLK);
    #2;
    check_output("fill word2 before reset", 128'(act_trace()), 128'(exp_trace(v, 1'b0, 2 * MEM_LAT + 1)));
    RSTn = 1'b0;
    miss_req = 1'b0;
    #1;
    check_output("mid-op reset outputs", 128'(act_trace()), 128'(IDLE_TRACE));
    check_output("mid-op reset refill", {refill_addr, refill_line[95:0]}, 128'd0);
    check_output("mid-op reset line top", 128'(refill_line[127:96]), 128'd0);
    @(negedge CLK) RSTn = 1'b1;
    seen = 0;
    for (int c = 0; c < 4 * MEM_LAT + 4; c++) begin
      @(posedge CLK);
      #2;
      if (refill_valid || busy) seen++;
    end
    check_output("no activity after reset", 128'(seen), 128'd0);
    apply_stimulus(tbl[5]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
# dcache_refill_ctrl

Miss-handling stage directly downstream of the data cache in the pipelined core. It accepts a line-miss request from the cache, writes back the dirty victim line to data memory if needed, fetches the replacement 4-word line word-by-word, and hands the assembled line back to the cache in one pulse. Data memory has a fixed multi-cycle access latency, and this block is the only master driving the data-memory port while a miss is outstanding.

## Interface
Parameters:
- MEM_LAT, 2, cycles per data-memory word access (legal range 1..15)
- LINE_WORDS, 4, words per cache line (fixed; not overridable)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RSTn  in  1  reset; asynchronous, active-low
- miss_req  in  1  cache requests a refill; held high until refill_valid
- miss_addr  in  32  byte address of the missing access; bits [3:0] ignored
- victim_dirty  in  1  victim line holds modified data
- victim_addr  in  32  line-aligned address of the victim; bits [3:0] ignored
- victim_line  in  128  victim data, word 0 in bits [31:0]
- busy  out  1  miss in progress (WB/FILL states)
- refill_valid  out  1  one-cycle pulse: refill_line/refill_addr valid
- refill_addr  out  32  line-aligned address of the refilled line
- refill_line  out  128  fetched line, word 0 in bits [31:0]
- D_MEM_ADDR  out  32  data-memory word address
- D_MEM_DO  out  32  write data to data memory
- D_MEM_WEN  out  1  data-memory write enable, active-low
- D_MEM_DI  in  32  read data from data memory

## Operation
- States: IDLE, WB, FILL, DONE.
- IDLE: on an edge with miss_req=1, capture miss_addr[31:4], victim_addr[31:4], victim_line, and victim_dirty. Go to WB if victim_dirty=1, else FILL. Clear word counter and latency counter.
- WB: for word w = 0..3, drive D_MEM_ADDR = {victim_addr[31:4], w, 2'b00}, D_MEM_DO = victim word w, and D_MEM_WEN = 0 for all MEM_LAT cycles of that word. After word 3 completes, go to FILL.
- FILL: for word w = 0..3, drive D_MEM_ADDR = {miss_addr[31:4], w, 2'b00} with D_MEM_WEN = 1. Capture D_MEM_DI into refill_line word w on the last (MEM_LAT-th) cycle of that word. After word 3, go to DONE.
- DONE: refill_valid = 1 for exactly one cycle, refill_addr = {miss_addr[31:4], 4'b0}; then go to IDLE.
- Word order is always ascending from word 0; there is no critical-word-first.
- Counters: latency counter is 4 bits and counts 0..MEM_LAT-1. Word counter is 2 bits; it advances when the latency counter wraps, and a wrap from 3 ends the state.
- Captured request fields are frozen for the whole transaction. Input changes after acceptance are ignored.
- miss_req dropping mid-transaction does not abort; DONE still occurs.
- miss_req high during DONE is not accepted. Acceptance is only possible in IDLE, so the earliest next accept is the cycle after DONE.
- Outside WB: D_MEM_WEN = 1 and D_MEM_DO = 0. In IDLE and DONE: D_MEM_ADDR = 0.
- refill_line and refill_addr hold their last values until overwritten by the next FILL.

## Timing
- Reset values: state IDLE, busy 0, refill_valid 0, refill_addr 0, refill_line 0, D_MEM_ADDR 0, D_MEM_DO 0, D_MEM_WEN 1, all counters 0.
- All outputs are registered or decoded from state/counter registers only. There is no combinational path from miss_req to any output.
- Acceptance edge = E0. busy rises in the cycle after E0 and falls on entry to DONE.
- Clean miss: FILL spans 4*MEM_LAT cycles, then DONE. refill_valid asserts in cycle 4*MEM_LAT+1 after E0.
- Dirty miss: WB spans 4*MEM_LAT cycles before FILL. refill_valid asserts in cycle 8*MEM_LAT+1 after E0.
- Reset asserted mid-transaction: immediately return to reset values. The memory write in flight is abandoned (D_MEM_WEN returns to 1 asynchronously), and no refill_valid is produced.

## Configuration
- DCACHE_WRITEBACK_EN defined: WB state present; dirty victims are written back as described.
- DCACHE_WRITEBACK_EN undefined: WB state, victim capture registers, and D_MEM_DO drive are compiled out. victim_dirty, victim_addr, and victim_line are ignored. D_MEM_WEN is tied to 1 and D_MEM_DO to 0, and every miss goes IDLE→FILL.

## Test plan
- Reset: RSTn=0 → busy 0, refill_valid 0, D_MEM_WEN 1, D_MEM_ADDR 0; these hold for 5 cycles after release with miss_req=0.
- Clean miss, MEM_LAT=2, miss_addr=0x0000_1234, memory words 0x11,0x22,0x33,0x44 at 0x1230..0x123C → D_MEM_ADDR steps 0x1230,0x1234,0x1238,0x123C, 2 cycles each. refill_valid is high in cycle 9 after E0 only, with refill_line=0x44_..._33_..._22_..._11 (word 0 at LSB) and refill_addr=0x1230.
- Dirty miss (WRITEBACK_EN), MEM_LAT=2, victim_addr=0x0000_2000, victim_line words 0xA0..0xA3, miss_addr=0x0000_3008 → D_MEM_WEN=0 for cycles 1–8 writing 0xA0..0xA3 to 0x2000..0x200C, then reads from 0x3000..0x300C. refill_valid is in cycle 17 with refill_addr=0x3000.
- Input churn: after E0, set miss_req=0 and change miss_addr=0xFFFF_FFF0 → the transaction still completes using the original address, and refill_valid pulses once.
- Back-to-back: miss_req held high through DONE → the second request is accepted on the edge after DONE, and no miss is lost or duplicated.
- Mid-op reset: assert RSTn=0 during FILL word 2 → outputs return to reset values in the same cycle, with no refill_valid; a new miss after release completes normally.
